// File: rtl/rotl_iter.sv
// Iterative rotate-left unit: one amount bit resolved per clock,
// registered log-shifter behind valid/ready handshakes.
module rotl_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] amt_q;
  logic [SHAMT_W-1:0] stg;
  logic [SHAMT_W-1:0] amt_sh;
  logic [SHAMT_W-1:0] step;
  logic [2*WIDTH-1:0] dbl;
  logic               accept;
  logic               last;
  logic               bit_on;

  assign accept = in_valid && in_ready;
  assign last   = (stg == SHAMT_W'(SHAMT_W - 1));
  assign amt_sh = amt_q >> stg;
  assign bit_on = amt_sh[0];
  assign step   = SHAMT_W'(1) << stg;
  // upper half of the doubled word is the wrapped rotate by 2^stg
  assign dbl    = {data_q, data_q} << step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = BUSY;
      BUSY: if (last) state_nx = DONE;
      DONE: begin
        if (accept) begin
          state_nx = BUSY;
        end else if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      BUSY: begin
        in_ready = 1'b0;
      end
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign out_data = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      amt_q  <= '0;
      stg    <= '0;
    end else if (accept) begin
      data_q <= in_data;
      amt_q  <= in_amt;
      stg    <= '0;
    end else if (state == BUSY) begin
      if (bit_on) begin
        data_q <= dbl[2*WIDTH-1:WIDTH];
      end
      if (!last) begin
        stg <= stg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rotl_iter.sv
// Bench for rotl_iter: bit-by-bit rotate model, per-cycle
// handshake/latency scoreboard and directed vectors.
module tb_rotl_iter;

  localparam int W = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic [S-1:0] in_amt = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           hs_cyc[$];
  logic         ev;

  rotl_iter #(.WIDTH(W), .SHAMT_W(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] rotl_ref(logic [W-1:0] x, int a);
    logic [W-1:0] r;
    r = x;
    for (int i = 0; i < a; i++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: result due 5 edges after the accept edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
    end else begin
      ev = (exp_q.size() > 0) && (cyc >= due_q[0]);
      chk("out_valid", W'(out_valid), W'(ev));
      chk("busy", W'(busy), W'(exp_q.size() > 0));
      chk("in_ready", W'(in_ready),
          W'((exp_q.size() == 0) || (ev && out_ready)));
      if (ev) begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
          hs_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(rotl_ref(in_data, int'(in_amt)));
        due_q.push_back(cyc + 6);
      end
    end
  end

  task automatic send(logic [W-1:0] d, logic [S-1:0] a);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout data %h", d);
    end
    @(posedge clk);
    #1;
    in_data = ~d;
    in_amt  = ~a;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!busy && !out_valid) return;
    end
    errors++;
    $display("FAIL idle_timeout busy %b", busy);
  endtask

  task automatic run(logic [W-1:0] d, logic [S-1:0] a);
    send(d, a);
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_out_valid"}, W'(out_valid), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_out_data"}, out_data, '0);
  endtask

  initial begin
    int n;
    chk("ref_inv3", rotl_ref(32'h02468ACF, 3), 32'h12345678);
    chk("ref_31", rotl_ref(32'h00000007, 31), 32'h80000003);
    chk("ref_msb", rotl_ref(32'h80000000, 1), 32'h00000001);
    chk("ref_amt0", rotl_ref(32'hDEADBEEF, 0), 32'hDEADBEEF);
    chk("ref_20", rotl_ref(32'h0000F000, 20), 32'h0000000F);
    chk("ref_8", rotl_ref(32'h12345678, 8), 32'h34567812);

    #12;
    chk_reset_outs("rst0");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(32'h00000001, 5'd3);
    run(32'h02468ACF, 5'd3);
    run(32'h00000007, 5'd31);
    run(32'h80000000, 5'd1);
    run(32'hDEADBEEF, 5'd0);
    run(32'hFFFFFFFF, 5'd5);
    run(32'hFFFFFFFF, 5'd17);
    run(32'hFFFFFFFF, 5'd31);

    out_ready = 1'b1;
    send(32'h00000001, 5'd4);
    send(32'h0000F000, 5'd20);
    in_valid = 1'b0;
    wait_idle();
    n = hs_cyc.size();
    if (n >= 2) chk("b2b_spacing", W'(hs_cyc[n-1] - hs_cyc[n-2]), W'(6));
    else chk("b2b_count", W'(n), W'(2));

    out_ready = 1'b0;
    send(32'hA5A50F0F, 5'd13);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("stall_valid", W'(out_valid), W'(1));
      chk("stall_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    wait_idle();

    send(32'hFFFF0000, 5'd7);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outs("post_rst");
    run(32'h12345678, 5'd8);
    chk("final_data", out_data, 32'h34567812);

    chk("result_count", W'(hs_cyc.size()), W'(12));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
